// File: rtl/uart_frame_rcv.sv
// uart_frame_rcv: oversampling asynchronous serial frame receiver.
// Frame = start(0), DATA_BITS data LSB-first, optional even parity, stop(1).
// Each bit is sampled at mid-bit. Accepted payloads land in a one-entry
// holding register with a ready/read handshake and error flags.
// Optional feature macro: RCV_PARITY_EN (adds an even-parity bit after the data).
module uart_frame_rcv #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 parity_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef RCV_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_LOAD
  } state_t;

  state_t                r_state, w_next;
  logic                  r_prev;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bitcnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_stop;
  logic                  w_edge, w_half, w_full, w_par_bad, w_load;

  assign w_edge = r_prev & ~serial_in;
  assign w_half = (r_cnt == HALF_M1);
  assign w_full = (r_cnt == FULL_M1);

`ifdef RCV_PARITY_EN
  logic r_par;
  logic r_perr;
  // Data bits plus parity bit must have even weight.
  assign w_par_bad    = ^{r_par, r_shift};
  assign parity_error = r_perr;
`else
  assign w_par_bad    = 1'b0;
  assign parity_error = 1'b0;
`endif

  // A frame is only committed when its stop bit was 1 and parity held.
  assign w_load = (r_state == ST_LOAD) && r_stop && !w_par_bad;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: each sampling state advances when the clock counter hits its mark.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_edge) w_next = ST_START;
      ST_START: if (w_half) w_next = serial_in ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (w_full && (r_bitcnt == LAST_BIT)) begin
`ifdef RCV_PARITY_EN
          w_next = ST_PARITY;
`else
          w_next = ST_STOP;
`endif
        end
      end
`ifdef RCV_PARITY_EN
      ST_PARITY: if (w_full) w_next = ST_STOP;
`endif
      ST_STOP:  if (w_full) w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Line history, bit-time counter, bit counter and sample capture.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_prev   <= 1'b1;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_stop   <= 1'b0;
`ifdef RCV_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_prev <= serial_in;
      // Counter restarts after the half-bit start sample so later samples sit mid-bit.
      if (r_state == ST_IDLE || r_state == ST_LOAD || (r_state == ST_START && w_half) || w_full)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (r_state == ST_IDLE)
        r_bitcnt <= '0;
      if (r_state == ST_DATA && w_full) begin
        r_shift  <= {serial_in, r_shift[DATA_BITS-1:1]};
        r_bitcnt <= r_bitcnt + 1'b1;
      end
`ifdef RCV_PARITY_EN
      if (r_state == ST_PARITY && w_full)
        r_par <= serial_in;
`endif
      if (r_state == ST_STOP && w_full)
        r_stop <= serial_in;
    end
  end

  // Holding register, handshake and error flags; a load beats a same-cycle read.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
`ifdef RCV_PARITY_EN
      r_perr        <= 1'b0;
`endif
    end else begin
      if (r_state == ST_IDLE && w_edge) begin
        framing_error <= 1'b0;
`ifdef RCV_PARITY_EN
        r_perr        <= 1'b0;
`endif
      end
      if (r_state == ST_LOAD) begin
        if (!r_stop)
          framing_error <= 1'b1;
`ifdef RCV_PARITY_EN
        else if (w_par_bad)
          r_perr <= 1'b1;
`endif
      end
      if (w_load) begin
        rx_data       <= r_shift;
        data_ready    <= 1'b1;
        overrun_error <= data_ready & ~data_read;
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_frame_rcv.md
# uart_frame_rcv

Asynchronous serial frame receiver that consumes the output of the reset-high input synchronizer. Line idles high and frames are LSB-first: one start bit (0), DATA_BITS data bits, optional parity, one stop bit (1). It oversamples at CLKS_PER_BIT clocks per bit and samples each bit at mid-bit. Assembled bytes go to a one-entry holding register with ready/read handshake and error flags for the downstream consumer.

## Interface
- CLKS_PER_BIT, default 10, clocks per serial bit; legal range 4..1023
- DATA_BITS, default 8, data bits per frame; legal range 5..9
- clk  input  1  system clock, rising-edge
- n_rst  input  1  reset, asynchronous, active-low
- serial_in  input  1  synchronized serial line; idle 1
- data_read  input  1  consumer pulse; clears data_ready and overrun_error
- rx_data  output  DATA_BITS  last accepted frame payload
- data_ready  output  1  rx_data holds unread data
- overrun_error  output  1  frame accepted while data_ready=1 and unread
- framing_error  output  1  last frame had stop bit = 0
- parity_error  output  1  last frame failed parity; tied 0 without RCV_PARITY_EN

## Operation
- Reset values: rx_data=0, data_ready=0, overrun_error=0, framing_error=0, parity_error=0, FSM=IDLE, previous-line register=1, counters=0.
- Start edge: previous-line register tracks serial_in every cycle. Falling edge (prev=1, now=0) in IDLE → START.
- FSM states:
  - IDLE: wait for start edge. On the edge, clear framing_error and parity_error.
  - START: sample at half bit. Sampled 1 → false start, back to IDLE, no flags. Sampled 0 → DATA.
  - DATA: sample once per CLKS_PER_BIT. Shift each bit in LSB-first. After DATA_BITS samples → PARITY (if enabled) else STOP.
  - PARITY: sample one bit, record the mismatch → STOP.
  - STOP: sample the stop bit → LOAD.
  - LOAD: one cycle, then IDLE.
- In LOAD:
  - Stop=0: framing_error=1. Frame discarded; rx_data and data_ready unchanged.
  - Parity mismatch: parity_error=1. Frame discarded.
  - Otherwise: rx_data←shift register, data_ready←1.
  - If data_ready was already 1 and data_read is not asserted this cycle: overrun_error←1 and rx_data is overwritten.
- data_read: when asserted and no load occurs, clears data_ready and overrun_error.
- data_read and load in the same cycle: load wins. data_ready=1, overrun_error is not set, and any previous overrun_error is cleared.
- Bit counter width is ceil(log2(DATA_BITS+1)). Clock counter width is ceil(log2(CLKS_PER_BIT)). The clock counter wraps to 0 at CLKS_PER_BIT-1.
- Reset mid-frame aborts immediately to the reset values.

## Timing
- Let C=CLKS_PER_BIT, H=floor(C/2). Cycle 0 is the first rising edge at which serial_in=0 and prev=1.
- Start sample: cycle H.
- Data bit i (0-based): cycle H+(i+1)·C.
- Parity bit (if enabled): cycle H+(DATA_BITS+1)·C.
- Stop sample: cycle S=H+(DATA_BITS+1+P)·C, where P=1 if parity is enabled, else 0.
- rx_data, data_ready and error flags update at cycle S+1.
- FSM is in IDLE at cycle S+2. A start edge is recognized from that cycle on, so back-to-back frames with a 1-bit stop are supported.
- Outputs are registered. No combinational path from inputs to outputs.

## Configuration
- RCV_PARITY_EN defined: one even-parity bit follows the data bits. Parity is computed over the data bits plus the parity bit, and must be even. A mismatch sets parity_error and discards the frame. Stop sample moves one bit later.
- RCV_PARITY_EN undefined: no PARITY state, no parity sample, parity_error constantly 0.

## Test plan
- Valid frame (C=10, D=8, no parity): start, then bits 1,0,1,0,0,1,0,1, then stop=1 → at cycle 96, rx_data=0xA5, data_ready=1, all errors 0.
- False start: serial_in low for 3 cycles, then high → FSM returns to IDLE at cycle 6; data_ready stays 0, no error flags set.
- Framing error: frame 0x3C with stop=0 → framing_error=1 at cycle 96; rx_data and data_ready unchanged. Flag clears on the next start edge.
- Overrun and handshake:
  - 0x11 then 0x22 back-to-back, no data_read → rx_data=0x22, data_ready=1, overrun_error=1.
  - data_read pulse → both cleared next cycle.
  - data_read coincident with load → data_ready=1, overrun_error=0.
- Reset mid-frame: n_rst low at cycle 40 of frame 0x5A → all outputs 0 immediately. After release with line high, no data_ready.
- RCV_PARITY_EN build:
  - 0x07 with parity bit 1 → accepted at cycle 106.
  - Same frame with parity bit 0 → parity_error=1, data_ready unchanged.
